// File: rtl/imem_loadable.sv
// Synchronous-read instruction memory for the fetch stage: cleared to FILL after
// reset, reloadable word by word through a streaming load port.
module imem_loadable #(
    parameter int          N      = 32,
    parameter int          ADDR_W = 6,
    parameter logic [N-1:0] FILL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [N-1:0]      q,
    output logic              q_valid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [N-1:0]      ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  ld_count_reg, ld_count_next;
    logic              q_valid_reg, q_valid_next;
    logic              ld_ready_reg;
    logic              busy_reg;
    logic [N-1:0]      q_reg;

    logic [N-1:0]      mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;
    logic              rd_en;

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        ld_count_next = ld_count_reg;
        q_valid_next  = q_valid_reg;
        we            = 1'b0;
        waddr         = ptr_reg[ADDR_W-1:0];
        wdata         = FILL;
        rd_en         = 1'b0;
        case (state_reg)
            CLEAR: begin
                we       = 1'b1;
                ptr_next = ptr_reg + PTR_ONE;
                if (ptr_reg == LAST_PTR) begin
                    state_next = RUN;
                    ptr_next   = '0;
                end
            end
            RUN: begin
                if (fetch_en) begin
                    rd_en        = 1'b1;
                    q_valid_next = 1'b1;
                end
                // A fetch in the same cycle still reads the pre-load contents.
                if (ld_start) begin
                    q_valid_next  = 1'b0;
                    ptr_next      = '0;
                    ld_count_next = '0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                q_valid_next = 1'b0;
                if (ld_valid) begin
                    we       = 1'b1;
                    wdata    = ld_data;
                    ptr_next = ptr_reg + PTR_ONE;
                    if (ld_count_reg != DEPTH_CNT) begin
                        ld_count_next = ld_count_reg + PTR_ONE;
                    end
                    if (ld_last || (ptr_reg == LAST_PTR)) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            ptr_reg      <= '0;
            ld_count_reg <= '0;
            q_valid_reg  <= 1'b0;
            ld_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            ld_count_reg <= ld_count_next;
            q_valid_reg  <= q_valid_next;
            ld_ready_reg <= (state_next == LOAD);
            busy_reg     <= (state_next != RUN);
        end
    end

    // Writes are suppressed while reset is asserted so an interrupted load cannot land a word.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= FILL;
        end else if (rd_en) begin
            q_reg <= mem[addr];
        end
    end

    assign q        = q_reg;
    assign q_valid  = q_valid_reg;
    assign ld_ready = ld_ready_reg;
    assign ld_count = ld_count_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: clear sweep, loads, stall hold, overflow, simultaneous
// events and reset during a load.
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] q;
    logic        q_valid;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [6:0]  ld_count;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] model [64];

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } fetch_t;
    fetch_t sb[$];

    typedef struct {
        logic        fetch_en;
        logic [5:0]  addr;
        logic        ld_start;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        ld_last;
        logic [31:0] exp_q;
        logic        exp_qv;
        logic        exp_ready;
        logic        exp_busy;
        logic [6:0]  exp_count;
    } vec_t;
    vec_t vecs[7];

    imem_loadable #(.N(32), .ADDR_W(6), .FILL(32'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .addr(addr),
        .q(q),
        .q_valid(q_valid),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .ld_count(ld_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [5:0] a);
        fetch_t e;
        addr     = a;
        fetch_en = 1'b1;
        e.addr   = a;
        e.data   = model[a];
        sb.push_back(e);
        tick();
        fetch_en = 1'b0;
        e = sb.pop_front();
        check("fetch_q", q, e.data);
        check("fetch_valid", 32'(q_valid), 32'(1));
        $display("fetch addr %0d q %h expected %h", e.addr, q, e.data);
    endtask

    task automatic load_words(input int cnt, input logic [31:0] first, input logic [31:0] stride,
                              input bit use_last, input int gap_at);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ld_start_ready", 32'(ld_ready), 32'(1));
        check("ld_start_busy", 32'(busy), 32'(1));
        check("ld_start_qvalid", 32'(q_valid), 32'(0));
        check("ld_start_count", 32'(ld_count), 32'(0));
        for (int i = 0; i < cnt; i++) begin
            if (i == gap_at) begin
                ld_valid = 1'b0;
                ld_last  = 1'b1;
                tick();
                check("gap_count", 32'(ld_count), 32'(i));
                check("gap_ready", 32'(ld_ready), 32'(1));
            end
            ld_valid = 1'b1;
            ld_data  = first + 32'(i) * stride;
            ld_last  = use_last && (i == cnt - 1);
            tick();
            model[i] = ld_data;
            check("load_count", 32'(ld_count), 32'(i + 1));
            check("load_ready", 32'(ld_ready), 32'((ld_last || i == 63) ? 0 : 1));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("load_done_busy", 32'(busy), 32'(0));
        $display("load %0d words, ld_count %0d", cnt, ld_count);
    endtask

    task automatic sweep_after_release();
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        check("clear_cycles", 32'(cyc), 32'(64));
        $display("clear sweep finished after %0d cycles", cyc);
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd5, 1'b1, 1'b0, 32'h0,         1'b0, 32'ha0000005, 1'b0, 1'b1, 1'b1, 7'd0};
        vecs[1] = '{1'b1, 6'd6, 1'b1, 1'b1, 32'h55550000,  1'b0, 32'ha0000005, 1'b0, 1'b1, 1'b1, 7'd1};
        vecs[2] = '{1'b1, 6'd7, 1'b1, 1'b1, 32'h55550001,  1'b1, 32'ha0000005, 1'b0, 1'b0, 1'b0, 7'd2};
        vecs[3] = '{1'b1, 6'd0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h55550000, 1'b1, 1'b0, 1'b0, 7'd2};
        vecs[4] = '{1'b1, 6'd1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h55550001, 1'b1, 1'b0, 1'b0, 7'd2};
        vecs[5] = '{1'b1, 6'd2, 1'b0, 1'b0, 32'h0,         1'b0, 32'ha0000002, 1'b1, 1'b0, 1'b0, 7'd2};
        vecs[6] = '{1'b0, 6'd9, 1'b0, 1'b0, 32'h0,         1'b0, 32'ha0000002, 1'b1, 1'b0, 1'b0, 7'd2};

        // Reset state
        tick();
        tick();
        check("rst_q", q, 32'h0);
        check("rst_qvalid", 32'(q_valid), 32'(0));
        check("rst_ready", 32'(ld_ready), 32'(0));
        check("rst_count", 32'(ld_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));

        // Clear sweep: busy high through edge 63, low after edge 64
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            check("clear_busy", 32'(busy), 32'((i < 64) ? 1 : 0));
        end
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        for (int i = 0; i < 64; i++) fetch_word(6'(i));

        // Load 47 words with an ignored ld_last gap, then read back
        load_words(47, 32'hf8000001, 32'h00008001, 1'b1, 10);
        check("load47_count", 32'(ld_count), 32'(47));
        check("load47_ready", 32'(ld_ready), 32'(0));
        fetch_word(6'd0);
        fetch_word(6'd46);
        fetch_word(6'd47);
        check("load46_value", model[46], 32'hf8000001 + 32'd46 * 32'h00008001);

        // Stall hold
        load_words(4, 32'h8b050080, 32'h1, 1'b1, -1);
        fetch_word(6'd3);
        for (int k = 0; k < 5; k++) begin
            fetch_en = 1'b0;
            addr     = 6'(k * 7 + 10);
            tick();
            check("stall_q", q, 32'h8b050083);
            check("stall_qvalid", 32'(q_valid), 32'(1));
            $display("stall cycle %0d q %h q_valid %0d", k, q, q_valid);
        end

        // Overflow: 64 words, no ld_last, keep driving afterwards
        load_words(64, 32'ha0000000, 32'h1, 1'b0, -1);
        check("ovf_count", 32'(ld_count), 32'(64));
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hdeadbeef;
            tick();
            check("ovf_extra_count", 32'(ld_count), 32'(64));
            check("ovf_extra_ready", 32'(ld_ready), 32'(0));
            check("ovf_extra_busy", 32'(busy), 32'(0));
        end
        ld_valid = 1'b0;
        fetch_word(6'd0);
        fetch_word(6'd63);

        // Simultaneous events, table driven
        for (int r = 0; r < 7; r++) begin
            fetch_en = vecs[r].fetch_en;
            addr     = vecs[r].addr;
            ld_start = vecs[r].ld_start;
            ld_valid = vecs[r].ld_valid;
            ld_data  = vecs[r].ld_data;
            ld_last  = vecs[r].ld_last;
            tick();
            check("vec_q", q, vecs[r].exp_q);
            check("vec_qvalid", 32'(q_valid), 32'(vecs[r].exp_qv));
            check("vec_ready", 32'(ld_ready), 32'(vecs[r].exp_ready));
            check("vec_busy", 32'(busy), 32'(vecs[r].exp_busy));
            check("vec_count", 32'(ld_count), 32'(vecs[r].exp_count));
            $display("vec %0d q %h q_valid %0d ld_ready %0d busy %0d ld_count %0d",
                     r, q, q_valid, ld_ready, busy, ld_count);
        end
        fetch_en = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // Reset in the middle of a load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hc0de0000 + 32'(i);
            tick();
        end
        check("midload_count", 32'(ld_count), 32'(10));
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 32'(ld_ready), 32'(0));
        check("midrst_qvalid", 32'(q_valid), 32'(0));
        check("midrst_count", 32'(ld_count), 32'(0));
        check("midrst_busy", 32'(busy), 32'(1));
        check("midrst_q", q, 32'h0);
        rst_n    = 1'b1;
        ld_valid = 1'b0;
        sweep_after_release();
        for (int i = 0; i < 64; i++) fetch_word(6'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous-read instruction memory for the pipelined ARM64 core. It replaces the fixed combinational ROM in the fetch stage. Contents are cleared to a fill word after reset and can be (re)loaded word by word through a streaming load port. Fetch reads are registered, with stall-hold semantics, so the IF stage sees a one-cycle read latency.

## Interface
- `N`, 32: instruction word width in bits.
- `ADDR_W`, 6: word-address width; `DEPTH = 2**ADDR_W` words.
- `FILL`, `'0`: word written to every location during the post-reset clear sweep.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fetch_en`  in  1  fetch request, sampled in RUN only; low means stall.
- `addr`  in  ADDR_W  fetch word index.
- `q`  out  N  registered instruction word.
- `q_valid`  out  1  `q` holds a word read in RUN.
- `ld_start`  in  1  one-cycle request to enter LOAD; honoured in RUN only.
- `ld_valid`  in  1  `ld_data` is valid this cycle.
- `ld_data`  in  N  word to write.
- `ld_last`  in  1  qualifies the final load word.
- `ld_ready`  out  1  block accepts load words (state == LOAD).
- `ld_count`  out  ADDR_W+1  words written in the current or most recent load.
- `busy`  out  1  high in CLEAR or LOAD.

## Operation
- States: CLEAR, RUN, LOAD. A 1-bit-wide-enough pointer `ptr` (ADDR_W+1 bits) is shared by CLEAR and LOAD.
- Reset (`rst_n`=0 at an edge):
  - state ← CLEAR, `ptr` ← 0.
  - `q` ← FILL, `q_valid` ← 0, `ld_ready` ← 0, `ld_count` ← 0, `busy` ← 1.
  - Applies from any state, including mid-LOAD; partial load contents are then cleared.
- CLEAR: writes `mem[ptr]` ← FILL each cycle and increments `ptr`. The cycle that writes index DEPTH-1 moves to RUN. `fetch_en` and `ld_*` are ignored.
- RUN:
  - `fetch_en`=1: `q` ← `mem[addr]`, `q_valid` ← 1.
  - `fetch_en`=0: `q` and `q_valid` hold.
  - `ld_start`=1: `ptr` ← 0, `ld_count` ← 0, move to LOAD. If `fetch_en`=1 in the same cycle, the fetch is still served and reads the pre-load contents.
- LOAD:
  - `q_valid` ← 0 on entry; `q` holds. `fetch_en` and `ld_start` are ignored.
  - Each cycle with `ld_valid`=1 (`ld_ready` is 1 throughout LOAD): `mem[ptr[ADDR_W-1:0]]` ← `ld_data`, `ptr`++, `ld_count`++.
  - Exit to RUN after the accepted word with `ld_last`=1, or after the DEPTH-th accepted word regardless of `ld_last`.
  - `ld_last` without `ld_valid` is ignored. Locations not written keep their prior contents.
- `ld_count` saturates at DEPTH, which is representable because it is ADDR_W+1 bits. It holds its value in RUN until the next `ld_start`.
- The memory has a single write port. A write and a read never occur in the same state.

## Timing
- Read latency: 1 cycle. `addr` sampled at edge k appears on `q` after edge k, i.e. valid in cycle k+1.
- The clear sweep takes exactly DEPTH cycles after the first edge with `rst_n`=1. `busy` falls and RUN begins on the cycle after the sweep: 64 cycles for ADDR_W=6.
- `ld_start` at edge k: `ld_ready` and `busy` are 1 and `q_valid` is 0 from cycle k+1. The first word can be accepted at edge k+1.
- Final load word accepted at edge j: `ld_ready` is 0 and `busy` is 0 from cycle j+1, and a fetch can be issued at edge j+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and clear** (ADDR_W=6, FILL=0): release `rst_n`. Required: `busy`=1 for 64 cycles then 0; fetches of addr 0..63 return 0 with `q_valid`=1 one cycle after each request.
- **Load and readback**: `ld_start`, then 47 words `32'hf8000001`, `32'hf8008002`, … with `ld_last` on the 47th. Required: `ld_count`=47, `busy`=0 the cycle after the last word, fetch addr 0 → `32'hf8000001`, addr 46 → last word, addr 47 → 0.
- **Stall hold**: fetch addr 3 (`32'h8b050083`), then hold `fetch_en`=0 for 5 cycles while `addr` changes. Required: `q`=`32'h8b050083` and `q_valid`=1 throughout.
- **Overflow**: load 64 words with `ld_last` never asserted, then continue driving `ld_valid`. Required: exit to RUN after word 64, `ld_count`=64, and the extra words are not written (addr 0 unchanged).
- **Simultaneous events**: `ld_start` with `fetch_en`=1 at addr 5 in the same cycle. Required: `q` shows the old `mem[5]` and `q_valid` drops to 0 in the next cycle. In LOAD, `ld_start` and `fetch_en` have no effect.
- **Reset mid-load**: drive `rst_n`=0 after 10 load words. Required: `ld_ready`=0, `q_valid`=0, `ld_count`=0; after the 64-cycle sweep all locations read FILL.
